// File: rtl/ahb3lite_sram_slave.sv
// ahb3lite_sram_slave
//   AHB3-Lite on-chip SRAM slave with MEM_DEPTH words of MEM_SIZE bits.
//   Legal transfers complete with zero wait states and an OKAY response.
//   Illegal accesses (HSIZE > 2, misaligned, or out of range) get a two-cycle ERROR response
//   and leave the memory unchanged.
//
// Ports
//   hclk_i       bus clock; all logic runs on the rising edge
//   hreset_i     synchronous, active-high reset
//   hsel_i       slave select
//   haddr_i      byte address (address phase)
//   hwdata_i     write data (data phase)
//   hrdata_o     read data (data phase); zero outside a legal read data phase
//   hwrite_i     1 = write, 0 = read
//   hsize_i      0 = byte, 1 = half, 2 = word; larger values are illegal
//   hburst_i     accepted, no effect
//   hprot_i      accepted, no effect
//   htrans_i     0 = IDLE, 1 = BUSY, 2 = NONSEQ, 3 = SEQ
//   hready_i     bus-wide ready; the address phase is sampled only when this is 1
//   hreadyout_o  slave ready
//   hresp_o      0 = OKAY, 1 = ERROR
module ahb3lite_sram_slave #(
  parameter int unsigned MEM_SIZE   = 32,
  parameter int unsigned MEM_DEPTH  = 256,
  parameter int unsigned HADDR_SIZE = 32,
  parameter int unsigned HDATA_SIZE = 32
) (
  input  logic                  hclk_i,
  input  logic                  hreset_i,
  input  logic                  hsel_i,
  input  logic [HADDR_SIZE-1:0] haddr_i,
  input  logic [HDATA_SIZE-1:0] hwdata_i,
  output logic [HDATA_SIZE-1:0] hrdata_o,
  input  logic                  hwrite_i,
  input  logic [2:0]            hsize_i,
  input  logic [2:0]            hburst_i,
  input  logic [3:0]            hprot_i,
  input  logic [1:0]            htrans_i,
  input  logic                  hready_i,
  output logic                  hreadyout_o,
  output logic                  hresp_o
);

  localparam int unsigned IdxW = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {StIdle, StData, StErr1, StErr2} state_e;

  state_e              state_q;
  logic [IdxW-1:0]     idx_q;
  logic                write_q;
  logic [3:0]          be_q;
  logic                hreadyout_q;
  logic                hresp_q;
  logic [MEM_SIZE-1:0] mem_q [MEM_DEPTH];

  logic            accept;
  logic            misaligned;
  logic            out_of_range;
  logic            illegal;
  logic [3:0]      be_d;
  logic [IdxW-1:0] idx_d;

  // Only the NONSEQ/SEQ bit of htrans matters; burst type and protection are ignored.
  logic unused_ok;
  assign unused_ok = ^{hburst_i, hprot_i, htrans_i[0]};

  // ERR1 drives hreadyout low, so hready_i is already 0 there; the state term keeps the
  // address phase ignored even if the interconnect does not feed hreadyout back.
  assign accept       = hsel_i & hready_i & htrans_i[1] & (state_q != StErr1);
  assign misaligned   = ((hsize_i == 3'd1) & haddr_i[0]) | ((hsize_i == 3'd2) & (|haddr_i[1:0]));
  assign out_of_range = |haddr_i[HADDR_SIZE-1:IdxW+2];
  assign illegal      = (hsize_i > 3'd2) | misaligned | out_of_range;
  assign idx_d        = haddr_i[IdxW+1:2];

  always_comb begin
    be_d = 4'b0000;
    case (hsize_i)
      3'd0:    be_d = 4'b0001 << haddr_i[1:0];
      3'd1:    be_d = haddr_i[1] ? 4'b1100 : 4'b0011;
      3'd2:    be_d = 4'b1111;
      default: be_d = 4'b0000;
    endcase
  end

  // Transfer FSM with registered response outputs.
  always_ff @(posedge hclk_i) begin
    if (hreset_i) begin
      state_q     <= StIdle;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      idx_q       <= '0;
      write_q     <= 1'b0;
      be_q        <= 4'b0000;
    end else begin
      case (state_q)
        StErr1: begin
          state_q     <= StErr2;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b1;
        end
        default: begin
          // StIdle, StData and StErr2 all complete this cycle and may take a new address.
          if (accept) begin
            idx_q   <= idx_d;
            write_q <= hwrite_i;
            be_q    <= be_d;
            if (illegal) begin
              state_q     <= StErr1;
              hreadyout_q <= 1'b0;
              hresp_q     <= 1'b1;
            end else begin
              state_q     <= StData;
              hreadyout_q <= 1'b1;
              hresp_q     <= 1'b0;
            end
          end else begin
            state_q     <= StIdle;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
          end
        end
      endcase
    end
  end

  // Write commits at the end of the data phase, so a read data phase in the next cycle
  // already sees the new word. Reset during the data phase discards the write.
  always_ff @(posedge hclk_i) begin
    if (!hreset_i && (state_q == StData) && write_q) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be_q[i]) begin
          mem_q[idx_q][8*i +: 8] <= hwdata_i[8*i +: 8];
        end
      end
    end
  end

  assign hrdata_o    = ((state_q == StData) && !write_q) ? mem_q[idx_q] : '0;
  assign hreadyout_o = hreadyout_q;
  assign hresp_o     = hresp_q;

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Testbench for ahb3lite_sram_slave: directed transfers plus randomized traffic, checked
// against a byte-addressed reference memory and a transfer-level response model.
module tb_ahb3lite_sram_slave;

  logic        clk = 1'b0;
  logic        hreset_i;
  logic        hsel_i;
  logic [31:0] haddr_i;
  logic [31:0] hwdata_i;
  logic [31:0] hrdata_o;
  logic        hwrite_i;
  logic [2:0]  hsize_i;
  logic [2:0]  hburst_i;
  logic [3:0]  hprot_i;
  logic [1:0]  htrans_i;
  logic        hreadyout_o;
  logic        hresp_o;

  always #5 clk = ~clk;

  ahb3lite_sram_slave dut (
    .hclk_i     (clk),
    .hreset_i   (hreset_i),
    .hsel_i     (hsel_i),
    .haddr_i    (haddr_i),
    .hwdata_i   (hwdata_i),
    .hrdata_o   (hrdata_o),
    .hwrite_i   (hwrite_i),
    .hsize_i    (hsize_i),
    .hburst_i   (hburst_i),
    .hprot_i    (hprot_i),
    .htrans_i   (htrans_i),
    .hready_i   (hreadyout_o),
    .hreadyout_o(hreadyout_o),
    .hresp_o    (hresp_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference memory, one entry per byte address.
  logic [7:0] ref_mem [1024];

  function automatic logic [31:0] ref_word(input int unsigned a);
    int unsigned base;
    base = a & ~32'd3;
    return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
  endfunction

  // Outstanding data phase as seen by the master.
  logic        p_valid = 1'b0;
  logic        p_legal = 1'b0;
  logic        p_write = 1'b0;
  logic        p_err2  = 1'b0;
  int unsigned p_addr  = 0;
  int unsigned p_size  = 0;
  logic [31:0] p_wdata = '0;

  logic        last_rdy;
  logic        last_resp;
  logic [31:0] last_rd;

  // One bus clock: presents an address phase (and the data for any pending write),
  // checks the responses of the pending data phase, then advances the model.
  task automatic bus_cycle(input logic rst, input logic sel, input logic [1:0] trans,
                           input logic wr, input logic [31:0] addr, input logic [2:0] size,
                           input logic [31:0] wdata);
    logic        exp_rdy;
    logic        exp_resp;
    logic [31:0] exp_rd;
    logic        acc;
    int unsigned nbytes;
    hreset_i = rst;
    hsel_i   = sel;
    htrans_i = trans;
    hwrite_i = wr;
    haddr_i  = addr;
    hsize_i  = size;
    hprot_i  = 4'($urandom);
    hwdata_i = (p_valid && p_legal && p_write) ? p_wdata : $urandom;

    exp_rdy  = 1'b1;
    exp_resp = 1'b0;
    exp_rd   = '0;
    if (p_valid && !p_legal) begin
      exp_resp = 1'b1;
      exp_rdy  = p_err2;
    end else if (p_valid && !p_write) begin
      exp_rd = ref_word(p_addr);
    end

    @(negedge clk);
    last_rdy  = hreadyout_o;
    last_resp = hresp_o;
    last_rd   = hrdata_o;
    check_eq("hreadyout", {31'b0, hreadyout_o}, {31'b0, exp_rdy});
    check_eq("hresp", {31'b0, hresp_o}, {31'b0, exp_resp});
    check_eq("hrdata", hrdata_o, exp_rd);

    acc = sel && trans[1] && exp_rdy;
    if (rst) begin
      p_valid = 1'b0;
      p_err2  = 1'b0;
    end else if (p_valid && !p_legal && !p_err2) begin
      p_err2 = 1'b1;
    end else begin
      if (p_valid && p_legal && p_write) begin
        nbytes = 1 << p_size;
        for (int unsigned b = 0; b < nbytes; b++) begin
          ref_mem[p_addr+b] = p_wdata[8*((p_addr+b)%4) +: 8];
        end
      end
      p_valid = acc;
      p_legal = (size <= 3'd2) && ((addr % (32'd1 << size)) == 0) && (addr < 32'd1024);
      p_write = wr;
      p_addr  = addr;
      p_size  = int'(size);
      p_wdata = wdata;
      p_err2  = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    bus_cycle(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 3'd2, 32'h0);
  endtask

  task automatic wr_cycle(input logic [1:0] trans, input logic [31:0] addr,
                          input logic [2:0] size, input logic [31:0] wdata);
    bus_cycle(1'b0, 1'b1, trans, 1'b1, addr, size, wdata);
  endtask

  task automatic rd_cycle(input logic [1:0] trans, input logic [31:0] addr);
    bus_cycle(1'b0, 1'b1, trans, 1'b0, addr, 3'd2, 32'h0);
  endtask

  localparam logic [1:0] Idle   = 2'b00;
  localparam logic [1:0] NonSeq = 2'b10;
  localparam logic [1:0] Seq    = 2'b11;

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    hreset_i = 1'b1;
    hsel_i   = 1'b0;
    htrans_i = Idle;
    hwrite_i = 1'b0;
    haddr_i  = '0;
    hsize_i  = 3'd2;
    hburst_i = 3'd0;
    hprot_i  = 4'd0;
    hwdata_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset_hreadyout", {31'b0, hreadyout_o}, 32'd1);
    check_eq("reset_hresp", {31'b0, hresp_o}, 32'd0);
    check_eq("reset_hrdata", hrdata_o, 32'd0);
    @(posedge clk);
    #1;

    // Give the DUT and the model identical contents.
    for (int i = 0; i < 256; i++) wr_cycle(NonSeq, 32'(i * 4), 3'd2, 32'h0);
    idle_cycle();

    // Word write then read.
    wr_cycle(NonSeq, 32'h10, 3'd2, 32'hDEADBEEF);
    rd_cycle(NonSeq, 32'h10);
    idle_cycle();
    check_eq("word_rd", last_rd, 32'hDEADBEEF);
    check_eq("word_rd_rdy", {31'b0, last_rdy}, 32'd1);

    // Byte writes assembling a word.
    wr_cycle(NonSeq, 32'h20, 3'd0, 32'h11111111);
    wr_cycle(NonSeq, 32'h21, 3'd0, 32'h22222222);
    wr_cycle(NonSeq, 32'h22, 3'd0, 32'h33333333);
    wr_cycle(NonSeq, 32'h23, 3'd0, 32'h44444444);
    rd_cycle(NonSeq, 32'h20);
    idle_cycle();
    check_eq("byte_rd", last_rd, 32'h44332211);

    // Upper halfword write; the lower lanes of hwdata must be ignored.
    wr_cycle(NonSeq, 32'h30, 3'd2, 32'h0);
    wr_cycle(NonSeq, 32'h32, 3'd1, 32'hBEEF1234);
    rd_cycle(NonSeq, 32'h30);
    idle_cycle();
    check_eq("half_rd", last_rd, 32'hBEEF0000);

    // Out-of-range read; a write offered while hready is low must be ignored.
    rd_cycle(NonSeq, 32'h400);
    wr_cycle(NonSeq, 32'h10, 3'd2, 32'hCAFEF00D);
    check_eq("oor_err1_rdy", {31'b0, last_rdy}, 32'd0);
    check_eq("oor_err1_resp", {31'b0, last_resp}, 32'd1);
    idle_cycle();
    check_eq("oor_err2_rdy", {31'b0, last_rdy}, 32'd1);
    check_eq("oor_err2_resp", {31'b0, last_resp}, 32'd1);
    idle_cycle();
    check_eq("oor_after_resp", {31'b0, last_resp}, 32'd0);

    // Misaligned word read.
    rd_cycle(NonSeq, 32'h02);
    idle_cycle();
    check_eq("mis_err1_rdy", {31'b0, last_rdy}, 32'd0);
    check_eq("mis_err1_resp", {31'b0, last_resp}, 32'd1);
    idle_cycle();
    check_eq("mis_err2_resp", {31'b0, last_resp}, 32'd1);
    rd_cycle(NonSeq, 32'h10);
    idle_cycle();
    check_eq("err_no_update", last_rd, 32'hDEADBEEF);

    // INCR4 write burst followed back-to-back by an INCR4 read burst.
    hburst_i = 3'b011;
    for (int i = 0; i < 4; i++) wr_cycle((i == 0) ? NonSeq : Seq, 32'(32'h40 + 4 * i), 3'd2,
                                         32'(i + 1));
    for (int i = 0; i < 4; i++) begin
      rd_cycle((i == 0) ? NonSeq : Seq, 32'(32'h40 + 4 * i));
      check_eq("burst_rdy", {31'b0, last_rdy}, 32'd1);
      if (i > 0) check_eq("burst_rd", last_rd, 32'(i));
    end
    idle_cycle();
    check_eq("burst_rd_last", last_rd, 32'd4);
    hburst_i = 3'b000;

    // Reset during a write data phase discards the write.
    wr_cycle(NonSeq, 32'h10, 3'd2, 32'h12345678);
    bus_cycle(1'b1, 1'b0, Idle, 1'b0, 32'h0, 3'd2, 32'h0);
    idle_cycle();
    check_eq("post_rst_rdy", {31'b0, last_rdy}, 32'd1);
    check_eq("post_rst_resp", {31'b0, last_resp}, 32'd0);
    rd_cycle(NonSeq, 32'h10);
    idle_cycle();
    check_eq("rst_discard", last_rd, 32'hDEADBEEF);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      logic        r_sel;
      logic        r_rst;
      logic [2:0]  r_size;
      logic [31:0] r_addr;
      r_sel  = ($urandom_range(0, 7) != 0);
      r_rst  = ($urandom_range(0, 99) == 0);
      r_size = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      r_addr = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 1023));
      if (r_size <= 3'd2 && $urandom_range(0, 7) != 0) r_addr = r_addr & ~((32'd1 << r_size) - 1);
      hburst_i = 3'($urandom);
      bus_cycle(r_rst, r_sel, 2'($urandom), 1'($urandom), r_addr, r_size, $urandom);
    end
    idle_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
